color_channel_select: RTL and testbench

Parametrised successor to the single-mode grayscale/luma stage in the camera path. It unpacks packed RGB pixels from the camera front end and produces one 8-bit channel per pixel in any of eight modes: grayscale, R, G, B, Y, Cr, Cb, or a luma threshold mask. The active mode is selected per frame and carried with each pixel through the pipeline. Output pixel, valid, hcount and vcount stay aligned at a fixed, parametrised latency and feed the frame-buffer write path.

---
 rtl/color_pkg.sv | 30 +++
 rtl/rgb_to_ycrcb.sv | 50 +++++
 rtl/color_channel_select.sv | 172 +++++++++++++++++
 tb/tb_color_channel_select.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared types and helpers for the colour channel selection path:
// mode encoding, converter depth and channel expansion.
package color_pkg;

   typedef enum logic [2:0] {
      MODE_GRAY   = 3'd0,
      MODE_R      = 3'd1,
      MODE_G      = 3'd2,
      MODE_B      = 3'd3,
      MODE_Y      = 3'd4,
      MODE_CR     = 3'd5,
      MODE_CB     = 3'd6,
      MODE_THRESH = 3'd7
   } mode_e;

   localparam int CONV_LATENCY = 3;

   // Left-justify a narrow colour field into 8 bits, zero-filling the LSBs.
   function automatic logic [7:0] expand_field(input logic [7:0] field, input int bits);
      expand_field = field << (8 - bits);
   endfunction

   function automatic logic [7:0] gray_of(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
      logic [9:0] sum;
      sum     = {2'b00, r} + {2'b00, g} + {2'b00, b};
      gray_of = 8'((sum >> 2) + (sum >> 4) + (sum >> 6));
   endfunction

endpackage

// File: rtl/rgb_to_ycrcb.sv
// Fixed-point RGB to YCrCb converter (full-range BT.601 style weights),
// three registered stages, no reset.
module rgb_to_ycrcb (
   input  logic       clk_in,
   input  logic [7:0] r_in,
   input  logic [7:0] g_in,
   input  logic [7:0] b_in,
   output logic [7:0] y_out,
   output logic [7:0] cr_out,
   output logic [7:0] cb_out
);

   logic [7:0]  r_d, g_d, b_d, r_q, g_q, b_q;
   logic [7:0]  y1_d, cr1_d, cb1_d, y1_q, cr1_q, cb1_q;
   logic [7:0]  y2_d, cr2_d, cb2_d, y2_q, cr2_q, cb2_q;
   logic [15:0] r_w, g_w, b_w;

   // The 32768 offset keeps chroma sums non-negative, so 16-bit wrap-around is exact.
   always_comb begin
      r_d   = r_in;
      g_d   = g_in;
      b_d   = b_in;
      r_w   = {8'd0, r_q};
      g_w   = {8'd0, g_q};
      b_w   = {8'd0, b_q};
      y1_d  = 8'((16'd77 * r_w + 16'd150 * g_w + 16'd29 * b_w) >> 8);
      cr1_d = 8'((16'd32768 + 16'd128 * r_w - 16'd107 * g_w - 16'd21 * b_w) >> 8);
      cb1_d = 8'((16'd32768 + 16'd128 * b_w - 16'd43 * r_w - 16'd85 * g_w) >> 8);
      y2_d  = y1_q;
      cr2_d = cr1_q;
      cb2_d = cb1_q;
   end

   always_ff @(posedge clk_in) begin
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
      y1_q  <= y1_d;
      cr1_q <= cr1_d;
      cb1_q <= cb1_d;
      y2_q  <= y2_d;
      cr2_q <= cr2_d;
      cb2_q <= cb2_d;
   end

   assign y_out  = y2_q;
   assign cr_out = cr2_q;
   assign cb_out = cb2_q;

endmodule

// File: rtl/color_channel_select.sv
// Per-frame selectable single-channel extraction from packed RGB pixels with
// a fixed LATENCY-cycle alignment of pixel, valid, hcount and vcount.
module color_channel_select
   import color_pkg::*;
#(
   parameter int R_BITS  = 5,
   parameter int G_BITS  = 6,
   parameter int B_BITS  = 5,
   parameter int H_WIDTH = 11,
   parameter int V_WIDTH = 10,
   parameter int LATENCY = 3
) (
   input  logic                             clk_in,
   input  logic                             rst_in,
   input  logic [R_BITS+G_BITS+B_BITS-1:0]  rec_pixel,
   input  logic                             rec_valid,
   input  logic [H_WIDTH-1:0]               rec_hcount,
   input  logic [V_WIDTH-1:0]               rec_vcount,
   input  logic [2:0]                       selector,
   input  logic [7:0]                       threshold_in,
   output logic [7:0]                       result_pixel,
   output logic                             result_valid,
   output logic [H_WIDTH-1:0]               result_hcount,
   output logic [V_WIDTH-1:0]               result_vcount,
   output logic [2:0]                       active_mode
);

   localparam int PIX_BITS = R_BITS + G_BITS + B_BITS;
   localparam int DLY      = LATENCY - CONV_LATENCY;

   logic [7:0]         r8_s, g8_s, b8_s, direct_s;
   logic               frame_start_s;
   mode_e              mode_in_s;
   mode_e              active_mode_d, active_mode_q;
   logic [7:0]         thresh_d, thresh_q;

   logic               valid_d  [LATENCY];
   logic               valid_q  [LATENCY];
   logic [H_WIDTH-1:0] hcount_d [LATENCY];
   logic [H_WIDTH-1:0] hcount_q [LATENCY];
   logic [V_WIDTH-1:0] vcount_d [LATENCY];
   logic [V_WIDTH-1:0] vcount_q [LATENCY];

   mode_e              tag_d    [CONV_LATENCY];
   mode_e              tag_q    [CONV_LATENCY];
   logic [7:0]         direct_d [CONV_LATENCY];
   logic [7:0]         direct_q [CONV_LATENCY];
   logic [7:0]         thr_d    [CONV_LATENCY];
   logic [7:0]         thr_q    [CONV_LATENCY];

   logic [7:0]         y_s, cr_s, cb_s, sel_pixel_s, pix_out_s;

   // The frame-start pixel already uses the newly requested mode and threshold.
   always_comb begin
      r8_s          = expand_field(8'(rec_pixel[PIX_BITS-1 -: R_BITS]), R_BITS);
      g8_s          = expand_field(8'(rec_pixel[B_BITS +: G_BITS]), G_BITS);
      b8_s          = expand_field(8'(rec_pixel[0 +: B_BITS]), B_BITS);
      frame_start_s = rec_valid && (rec_hcount == {H_WIDTH{1'b0}})
                                && (rec_vcount == {V_WIDTH{1'b0}});
      if (frame_start_s) begin
         mode_in_s = mode_e'(selector);
         thresh_d  = threshold_in;
      end else begin
         mode_in_s = active_mode_q;
         thresh_d  = thresh_q;
      end
      active_mode_d = mode_in_s;
      case (mode_in_s)
         MODE_R:    direct_s = r8_s;
         MODE_G:    direct_s = g8_s;
         MODE_B:    direct_s = b8_s;
         MODE_GRAY: direct_s = gray_of(r8_s, g8_s, b8_s);
         default:   direct_s = gray_of(r8_s, g8_s, b8_s);
      endcase
   end

   always_comb begin
      valid_d[0]  = rec_valid;
      hcount_d[0] = rec_hcount;
      vcount_d[0] = rec_vcount;
      for (int k = 1; k < LATENCY; k++) begin
         valid_d[k]  = valid_q[k-1];
         hcount_d[k] = hcount_q[k-1];
         vcount_d[k] = vcount_q[k-1];
      end
      tag_d[0]    = mode_in_s;
      direct_d[0] = direct_s;
      thr_d[0]    = thresh_d;
      for (int k = 1; k < CONV_LATENCY; k++) begin
         tag_d[k]    = tag_q[k-1];
         direct_d[k] = direct_q[k-1];
         thr_d[k]    = thr_q[k-1];
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         active_mode_q <= MODE_GRAY;
         thresh_q      <= 8'd0;
         for (int k = 0; k < LATENCY; k++) valid_q[k] <= 1'b0;
         for (int k = 0; k < CONV_LATENCY; k++) tag_q[k] <= MODE_GRAY;
      end else begin
         active_mode_q <= active_mode_d;
         thresh_q      <= thresh_d;
         valid_q       <= valid_d;
         tag_q         <= tag_d;
      end
   end

   always_ff @(posedge clk_in) begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      direct_q <= direct_d;
      thr_q    <= thr_d;
   end

   rgb_to_ycrcb u_conv (
      .clk_in (clk_in),
      .r_in   (r8_s),
      .g_in   (g8_s),
      .b_in   (b8_s),
      .y_out  (y_s),
      .cr_out (cr_s),
      .cb_out (cb_s)
   );

   // Output choice follows the per-pixel tag so a frame never switches mode midway.
   always_comb begin
      case (tag_q[CONV_LATENCY-1])
         MODE_Y:      sel_pixel_s = y_s;
         MODE_CR:     sel_pixel_s = cr_s;
         MODE_CB:     sel_pixel_s = cb_s;
         MODE_THRESH: sel_pixel_s = (y_s >= thr_q[CONV_LATENCY-1]) ? 8'hFF : 8'h00;
         default:     sel_pixel_s = direct_q[CONV_LATENCY-1];
      endcase
   end

   if (DLY == 0) begin : g_no_dly
      assign pix_out_s = sel_pixel_s;
   end else begin : g_dly
      logic [7:0] pix_d [DLY];
      logic [7:0] pix_q [DLY];

      always_comb begin
         pix_d[0] = sel_pixel_s;
         for (int k = 1; k < DLY; k++) pix_d[k] = pix_q[k-1];
      end

      always_ff @(posedge clk_in) begin
         pix_q <= pix_d;
      end

      assign pix_out_s = pix_q[DLY-1];
   end

   // Data stages carry no reset, so outputs are forced to zero whenever valid is low.
   always_comb begin
      if (valid_q[LATENCY-1]) begin
         result_pixel  = pix_out_s;
         result_hcount = hcount_q[LATENCY-1];
         result_vcount = vcount_q[LATENCY-1];
      end else begin
         result_pixel  = 8'd0;
         result_hcount = {H_WIDTH{1'b0}};
         result_vcount = {V_WIDTH{1'b0}};
      end
   end

   assign result_valid = valid_q[LATENCY-1];
   assign active_mode  = active_mode_q;

endmodule

// File: tb/tb_color_channel_select.sv
// Bench for color_channel_select: LATENCY=3 and LATENCY=5 instances share one
// stimulus stream and are compared against an arithmetic reference model.
module tb_color_channel_select;

   localparam int NE = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] rec_pixel;
   logic        rec_valid;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [2:0]  selector;
   logic [7:0]  threshold;

   logic [7:0]  d3_pixel, d5_pixel;
   logic        d3_valid, d5_valid;
   logic [10:0] d3_h, d5_h;
   logic [9:0]  d3_v, d5_v;
   logic [2:0]  d3_mode, d5_mode;

   int checks   = 0;
   int failures = 0;

   int m_mode, m_th, e;
   bit in_valid_a [NE];
   bit rst_a      [NE];
   int exp_pix_a  [NE];
   int h_a        [NE];
   int v_a        [NE];

   always #5 clk = ~clk;

   color_channel_select #(.LATENCY(3)) dut3 (
      .clk_in(clk), .rst_in(rst), .rec_pixel(rec_pixel), .rec_valid(rec_valid),
      .rec_hcount(hcount), .rec_vcount(vcount), .selector(selector),
      .threshold_in(threshold), .result_pixel(d3_pixel), .result_valid(d3_valid),
      .result_hcount(d3_h), .result_vcount(d3_v), .active_mode(d3_mode)
   );

   color_channel_select #(.LATENCY(5)) dut5 (
      .clk_in(clk), .rst_in(rst), .rec_pixel(rec_pixel), .rec_valid(rec_valid),
      .rec_hcount(hcount), .rec_vcount(vcount), .selector(selector),
      .threshold_in(threshold), .result_pixel(d5_pixel), .result_valid(d5_valid),
      .result_hcount(d5_h), .result_vcount(d5_v), .active_mode(d5_mode)
   );

   function automatic int model_pixel(input int mode, input int th, input int pix);
      int r, g, b, s, y;
      r = ((pix >> 11) & 31) * 8;
      g = ((pix >> 5) & 63) * 4;
      b = (pix & 31) * 8;
      s = r + g + b;
      y = (77 * r + 150 * g + 29 * b) / 256;
      case (mode)
         0:       return (s / 4 + s / 16 + s / 64) % 256;
         1:       return r;
         2:       return g;
         3:       return b;
         4:       return y;
         5:       return (32768 + 128 * r - 107 * g - 21 * b) / 256;
         6:       return (32768 - 43 * r - 85 * g + 128 * b) / 256;
         default: return (y >= th) ? 255 : 0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_dut(input int lat, input string name, input logic valid,
                            input logic [7:0] pix, input logic [10:0] h,
                            input logic [9:0] v, input logic [2:0] mode);
      int src;
      bit ev;
      src = e - lat + 1;
      ev  = 1'b0;
      if (src >= 0) begin
         ev = in_valid_a[src];
         for (int i = src; i <= e; i++) if (rst_a[i]) ev = 1'b0;
      end
      chk({name, "_valid"}, 32'(valid), 32'(ev));
      chk({name, "_active_mode"}, 32'(mode), m_mode);
      if (ev) begin
         chk({name, "_pixel"}, 32'(pix), exp_pix_a[src]);
         chk({name, "_hcount"}, 32'(h), h_a[src]);
         chk({name, "_vcount"}, 32'(v), v_a[src]);
      end else if (rst_a[e]) begin
         chk({name, "_rst_pixel"}, 32'(pix), 32'd0);
         chk({name, "_rst_hcount"}, 32'(h), 32'd0);
         chk({name, "_rst_vcount"}, 32'(v), 32'd0);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (e >= NE) begin
         $display("FAIL model_capacity edge=%0d limit=%0d", e, NE);
         $fatal(1, "model history exhausted");
      end
      rst_a[e]      = rst;
      in_valid_a[e] = rec_valid && !rst;
      if (rst) begin
         m_mode = 0;
         m_th   = 0;
      end else if (rec_valid && hcount == 11'd0 && vcount == 10'd0) begin
         m_mode = int'(selector);
         m_th   = int'(threshold);
      end
      exp_pix_a[e] = model_pixel(m_mode, m_th, int'(rec_pixel));
      h_a[e]       = int'(hcount);
      v_a[e]       = int'(vcount);
      #1;
      check_dut(3, "L3", d3_valid, d3_pixel, d3_h, d3_v, d3_mode);
      check_dut(5, "L5", d5_valid, d5_pixel, d5_h, d5_v, d5_mode);
      e++;
   endtask

   task automatic drive(input bit r, input bit val, input logic [15:0] pix, input int h,
                        input int v, input logic [2:0] sel, input logic [7:0] th);
      rst       = r;
      rec_valid = val;
      rec_pixel = pix;
      hcount    = 11'(h);
      vcount    = 10'(v);
      selector  = sel;
      threshold = th;
      cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h1234, 0, 0, 3'd5, 8'd9);
   endtask

   initial begin
      int  hc, vc;
      bit  val, rr;
      e      = 0;
      m_mode = 0;
      m_th   = 0;

      // Reset
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h0000, 0, 0, 3'd0, 8'd0);
      chk("reset_mode", 32'(d3_mode), 32'd0);

      // Gray of full-white pixel
      drive(1'b0, 1'b1, 16'hFFFF, 0, 0, 3'd0, 8'd0);
      idle(2);
      chk("gray_ffff", 32'(d3_pixel), 32'd244);
      chk("gray_valid", 32'(d3_valid), 32'd1);
      chk("gray_hv", {d3_h, 11'd0, d3_v}, 32'd0);

      // Single colour modes
      drive(1'b0, 1'b1, 16'hF800, 0, 0, 3'd1, 8'd0);
      idle(2);
      chk("mode_r", 32'(d3_pixel), 32'd248);
      drive(1'b0, 1'b1, 16'h07E0, 0, 0, 3'd2, 8'd0);
      idle(2);
      chk("mode_g", 32'(d3_pixel), 32'd252);
      drive(1'b0, 1'b1, 16'h001F, 0, 0, 3'd3, 8'd0);
      idle(2);
      chk("mode_b", 32'(d3_pixel), 32'd248);

      // Mid-frame selector change is ignored until the next frame start
      drive(1'b0, 1'b1, 16'hFFFF, 0, 0, 3'd1, 8'd0);
      for (int h = 1; h <= 8; h++)
         drive(1'b0, 1'b1, 16'hFFFF, h, 0, (h >= 5) ? 3'd2 : 3'd1, 8'd0);
      idle(2);
      chk("midframe_still_r", 32'(d3_pixel), 32'd248);
      chk("midframe_mode", 32'(d3_mode), 32'd1);
      drive(1'b0, 1'b1, 16'hFFFF, 0, 0, 3'd2, 8'd0);
      idle(2);
      chk("newframe_g", 32'(d3_pixel), 32'd252);
      chk("newframe_mode", 32'(d5_mode), 32'd2);

      // Threshold mode
      drive(1'b0, 1'b1, 16'($urandom), 0, 0, 3'd7, 8'd0);
      for (int h = 1; h <= 5; h++) drive(1'b0, 1'b1, 16'($urandom), h, 0, 3'd7, 8'd0);
      idle(2);
      chk("thresh0_ff", 32'(d3_pixel), 32'hFF);
      drive(1'b0, 1'b1, 16'h0000, 0, 0, 3'd7, 8'd255);
      idle(2);
      chk("thresh255_00", 32'(d3_pixel), 32'h00);
      chk("thresh255_valid", 32'(d3_valid), 32'd1);

      // Reset in the middle of a stream
      for (int h = 0; h < 10; h++)
         drive(h == 5, 1'b1, 16'($urandom), h, 0, 3'd4, 8'd0);
      idle(6);
      chk("after_rst_mode", 32'(d3_mode), 32'd0);
      chk("after_rst_valid", 32'(d5_valid), 32'd0);

      // Random stream with gaps, frame starts, stray selector changes and rare resets
      hc = 0;
      vc = 0;
      for (int i = 0; i < 800; i++) begin
         val = ($urandom_range(0, 9) < 7);
         rr  = ($urandom_range(0, 99) == 0);
         drive(rr, val, 16'($urandom), hc, vc, 3'($urandom), 8'($urandom));
         if (val && !rr) begin
            hc++;
            if (hc == 12) begin
               hc = 0;
               vc = (vc + 1) % 3;
            end
         end
      end
      idle(6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
